execution_stage: RTL and testbench
==================================

EXECUTION_STAGE -- requirements
Module: execution_stage

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port STALL_EXECUTION_STAGE, input, 1 bit: hold the output register.
REQ-004 SHALL have port CLEAR_EXECUTION_STAGE, input, 1 bit: flush the output register to a bubble.
REQ-005 SHALL have port PC_IN, input, 32 bits: PC of the instruction in EX.
REQ-006 SHALL have ports RS1_ADDRESS and RS2_ADDRESS, input, 5 bits each: source register indices.
REQ-007 SHALL have ports RS1_DATA, RS2_DATA and IMM_DATA, input, 32 bits each: register-file operands and immediate.
REQ-008 SHALL have port ALU_INSTRUCTION, input, 5 bits: ALU opcode.
REQ-009 SHALL have ports ALU_IN1_MUX_SELECT and ALU_IN2_MUX_SELECT, input, 3 bits each: operand source selects.
REQ-010 SHALL have ports RD_DATA_DM1, RD_DATA_DM2, RD_DATA_DM3 and RD_DATA_WB, input, 32 bits each: forwarding data from later stages.
REQ-011 SHALL have inputs RD_ADDRESS_IN (5), DATA_CACHE_LOAD_IN (3), DATA_CACHE_STORE_IN (2), DATA_CACHE_STORE_DATA_IN (32), WRITE_BACK_MUX_SELECT_IN (1) and RD_WRITE_ENABLE_IN (1): sideband signals carried downstream.
REQ-012 SHALL have outputs RD_ADDRESS_OUT, DATA_CACHE_LOAD_OUT, DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA_OUT, WRITE_BACK_MUX_SELECT_OUT and RD_WRITE_ENABLE_OUT, each the same width as its *_IN counterpart: registered copies.
REQ-013 SHALL have output ALU_OUT, 32 bits (registered), and output BRANCH_TAKEN, 1 bit (combinational by default).

Function
REQ-014 SHALL select operand 1 by ALU_IN1_MUX_SELECT: 0 RS1_DATA, 1 PC_IN, 2 DM1, 3 DM2, 4 DM3, 5 WB, 6-7 zero.
REQ-015 SHALL select operand 2 by ALU_IN2_MUX_SELECT: 0 RS2_DATA, 1 IMM_DATA, 2 DM1, 3 DM2, 4 DM3, 5 WB, 6-7 zero.
REQ-016 SHALL force a forwarded operand (select 2-5) to zero when its RS1_ADDRESS or RS2_ADDRESS is 0.
REQ-017 SHALL implement these opcodes:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- 10 PASSB (result = operand 2).
- 11 LINK (result = PC_IN+4).
- 12-17 BEQ, BNE, BLT, BGE, BLTU, BGEU: result 0.
- 18-31: result 0, no branch.
REQ-018 SHALL use only operand2[4:0] as the shift amount; all arithmetic SHALL be modulo 2^32 with no overflow flag.
REQ-019 SHALL assert BRANCH_TAKEN only for opcodes 12-17 when the comparison of operand 1 against operand 2 holds, independent of stall and clear.
REQ-020 SHALL have 1-cycle latency: at each edge with neither control asserted, capture the result into ALU_OUT and all *_IN sideband signals into their *_OUT ports.
REQ-021 SHALL load zeros into all registered outputs when CLEAR_EXECUTION_STAGE is high; clear SHALL take priority over stall.
REQ-022 SHALL hold every registered output unchanged while STALL_EXECUTION_STAGE is high and CLEAR_EXECUTION_STAGE is low.

Reset
REQ-023 SHALL drive all registered outputs to 0 immediately while RST_N is low, including a reset asserted mid-stall; reset SHALL release synchronously to the next edge.

Configuration
REQ-024 SHALL register BRANCH_TAKEN when macro EX_BRANCH_TAKEN_REG_EN is defined: stalled, cleared and reset like the other registered outputs, 1-cycle latency. Without the macro, BRANCH_TAKEN SHALL be combinational.

Structure
REQ-025 SHALL place the opcode constants and the mux-select constants in shared package execution_stage_pkg.
REQ-026 SHALL implement the combinational ALU and branch comparator in one sub-module, execution_alu; the operand muxes and pipeline register live in the top module.

Verification
REQ-027 SHALL verify ADD with sel1=0, sel2=1, RS1_DATA=5, IMM=7: ALU_OUT=12 one edge later, and RD_ADDRESS_IN=3 with write enable 1 propagates to the outputs.
REQ-028 SHALL verify forwarding with sel1=2, DM1=0x10, RS1_ADDRESS=4, SUB, operand 2=1: ALU_OUT=0x0F; with RS1_ADDRESS=0, ALU_OUT=0xFFFFFFFF.
REQ-029 SHALL verify BLT with operands 0xFFFFFFFF and 1: BRANCH_TAKEN=1; with BLTU: BRANCH_TAKEN=0.
REQ-030 SHALL verify stall for 3 cycles: outputs held; then clear and stall together: all registered outputs 0 at the next edge.
REQ-031 SHALL verify SRA with 0x80000000 and shift amount 0x24: ALU_OUT=0xF8000000, using shift amount 4.
REQ-032 SHALL verify RST_N low asynchronously between edges: all registered outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/execution_stage_pkg.sv
// Shared constants and types for the execution stage.
// Opcodes, operand-select codes, pipeline register bundle.
package execution_stage_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;
    localparam logic [4:0] OP_LINK  = 5'd11;
    localparam logic [4:0] OP_BEQ   = 5'd12;
    localparam logic [4:0] OP_BNE   = 5'd13;
    localparam logic [4:0] OP_BLT   = 5'd14;
    localparam logic [4:0] OP_BGE   = 5'd15;
    localparam logic [4:0] OP_BLTU  = 5'd16;
    localparam logic [4:0] OP_BGEU  = 5'd17;

    localparam logic [2:0] SEL_REG  = 3'd0;
    localparam logic [2:0] SEL_ALT  = 3'd1;
    localparam logic [2:0] SEL_DM1  = 3'd2;
    localparam logic [2:0] SEL_DM2  = 3'd3;
    localparam logic [2:0] SEL_DM3  = 3'd4;
    localparam logic [2:0] SEL_WB   = 3'd5;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [4:0]  rd_addr;
        logic [2:0]  load;
        logic [1:0]  store;
        logic [31:0] store_data;
        logic        wb_sel;
        logic        rd_we;
    } ex_reg_t;

    function automatic logic is_fwd(input logic [2:0] sel);
        return (sel >= SEL_DM1) && (sel <= SEL_WB);
    endfunction

endpackage

// File: rtl/execution_stage_if.sv
// Sideband bundle carried through the execution stage.
// master: upstream driver of *_IN; slave: the stage.
interface execution_stage_if;

    logic [4:0]  RD_ADDRESS_IN;
    logic [2:0]  DATA_CACHE_LOAD_IN;
    logic [1:0]  DATA_CACHE_STORE_IN;
    logic [31:0] DATA_CACHE_STORE_DATA_IN;
    logic        WRITE_BACK_MUX_SELECT_IN;
    logic        RD_WRITE_ENABLE_IN;

    logic [4:0]  RD_ADDRESS_OUT;
    logic [2:0]  DATA_CACHE_LOAD_OUT;
    logic [1:0]  DATA_CACHE_STORE_OUT;
    logic [31:0] DATA_CACHE_STORE_DATA_OUT;
    logic        WRITE_BACK_MUX_SELECT_OUT;
    logic        RD_WRITE_ENABLE_OUT;

    modport master (
        output RD_ADDRESS_IN, DATA_CACHE_LOAD_IN,
        output DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA_IN,
        output WRITE_BACK_MUX_SELECT_IN, RD_WRITE_ENABLE_IN,
        input  RD_ADDRESS_OUT, DATA_CACHE_LOAD_OUT,
        input  DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA_OUT,
        input  WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT
    );

    modport slave (
        input  RD_ADDRESS_IN, DATA_CACHE_LOAD_IN,
        input  DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA_IN,
        input  WRITE_BACK_MUX_SELECT_IN, RD_WRITE_ENABLE_IN,
        output RD_ADDRESS_OUT, DATA_CACHE_LOAD_OUT,
        output DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA_OUT,
        output WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT
    );

endinterface

// File: rtl/execution_alu.sv
// Combinational ALU and branch comparator.
// Ports: a_i, b_i operands, pc_i, op_i; result_o, branch_o.
module execution_alu
    import execution_stage_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  op_i,
    output logic [31:0] result_o,
    output logic        branch_o
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = b_i[4:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;
    assign eq    = a_i == b_i;

    always_comb begin
        result_o = '0;
        branch_o = 1'b0;
        case (op_i)
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = a_i - b_i;
            OP_SLL:   result_o = a_i << shamt;
            OP_SLT:   result_o = {31'd0, lt_s};
            OP_SLTU:  result_o = {31'd0, lt_u};
            OP_XOR:   result_o = a_i ^ b_i;
            OP_SRL:   result_o = a_i >> shamt;
            OP_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
            OP_OR:    result_o = a_i | b_i;
            OP_AND:   result_o = a_i & b_i;
            OP_PASSB: result_o = b_i;
            OP_LINK:  result_o = pc_i + 32'd4;
            OP_BEQ:   branch_o = eq;
            OP_BNE:   branch_o = !eq;
            OP_BLT:   branch_o = lt_s;
            OP_BGE:   branch_o = !lt_s;
            OP_BLTU:  branch_o = lt_u;
            OP_BGEU:  branch_o = !lt_u;
            default: begin
                result_o = '0;
                branch_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/execution_stage.sv
// Execution stage: operand muxes, ALU, EX/MEM register.
// Ports: CLK, RST_N, STALL/CLEAR, operands, forwarding data,
// sideband bundle (sb), ALU_OUT, BRANCH_TAKEN.
// Macro EX_BRANCH_TAKEN_REG_EN registers BRANCH_TAKEN.
module execution_stage
    import execution_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL_EXECUTION_STAGE,
    input  logic        CLEAR_EXECUTION_STAGE,
    input  logic [31:0] PC_IN,
    input  logic [4:0]  RS1_ADDRESS,
    input  logic [4:0]  RS2_ADDRESS,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    input  logic [31:0] IMM_DATA,
    input  logic [4:0]  ALU_INSTRUCTION,
    input  logic [2:0]  ALU_IN1_MUX_SELECT,
    input  logic [2:0]  ALU_IN2_MUX_SELECT,
    input  logic [31:0] RD_DATA_DM1,
    input  logic [31:0] RD_DATA_DM2,
    input  logic [31:0] RD_DATA_DM3,
    input  logic [31:0] RD_DATA_WB,
    execution_stage_if.slave sb,
    output logic [31:0] ALU_OUT,
    output logic        BRANCH_TAKEN
);

    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] alu_res;
    logic        br_comb;
    ex_reg_t     ex_d;
    ex_reg_t     ex_q;

    // A forwarded operand for x0 must read as zero.
    always_comb begin
        op1 = '0;
        case (ALU_IN1_MUX_SELECT)
            SEL_REG: op1 = RS1_DATA;
            SEL_ALT: op1 = PC_IN;
            SEL_DM1: op1 = RD_DATA_DM1;
            SEL_DM2: op1 = RD_DATA_DM2;
            SEL_DM3: op1 = RD_DATA_DM3;
            SEL_WB:  op1 = RD_DATA_WB;
            default: op1 = '0;
        endcase
        if (is_fwd(ALU_IN1_MUX_SELECT) && RS1_ADDRESS == 5'd0)
            op1 = '0;
    end

    always_comb begin
        op2 = '0;
        case (ALU_IN2_MUX_SELECT)
            SEL_REG: op2 = RS2_DATA;
            SEL_ALT: op2 = IMM_DATA;
            SEL_DM1: op2 = RD_DATA_DM1;
            SEL_DM2: op2 = RD_DATA_DM2;
            SEL_DM3: op2 = RD_DATA_DM3;
            SEL_WB:  op2 = RD_DATA_WB;
            default: op2 = '0;
        endcase
        if (is_fwd(ALU_IN2_MUX_SELECT) && RS2_ADDRESS == 5'd0)
            op2 = '0;
    end

    execution_alu u_alu (
        .a_i      (op1),
        .b_i      (op2),
        .pc_i     (PC_IN),
        .op_i     (ALU_INSTRUCTION),
        .result_o (alu_res),
        .branch_o (br_comb)
    );

    // Clear beats stall; stall holds; otherwise capture.
    always_comb begin
        ex_d = ex_q;
        if (CLEAR_EXECUTION_STAGE) begin
            ex_d = '0;
        end else if (!STALL_EXECUTION_STAGE) begin
            ex_d.alu_out    = alu_res;
            ex_d.rd_addr    = sb.RD_ADDRESS_IN;
            ex_d.load       = sb.DATA_CACHE_LOAD_IN;
            ex_d.store      = sb.DATA_CACHE_STORE_IN;
            ex_d.store_data = sb.DATA_CACHE_STORE_DATA_IN;
            ex_d.wb_sel     = sb.WRITE_BACK_MUX_SELECT_IN;
            ex_d.rd_we      = sb.RD_WRITE_ENABLE_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ALU_OUT                      = ex_q.alu_out;
    assign sb.RD_ADDRESS_OUT            = ex_q.rd_addr;
    assign sb.DATA_CACHE_LOAD_OUT       = ex_q.load;
    assign sb.DATA_CACHE_STORE_OUT      = ex_q.store;
    assign sb.DATA_CACHE_STORE_DATA_OUT = ex_q.store_data;
    assign sb.WRITE_BACK_MUX_SELECT_OUT = ex_q.wb_sel;
    assign sb.RD_WRITE_ENABLE_OUT       = ex_q.rd_we;

`ifdef EX_BRANCH_TAKEN_REG_EN
    logic br_d;
    logic br_q;

    always_comb begin
        br_d = br_q;
        if (CLEAR_EXECUTION_STAGE)       br_d = 1'b0;
        else if (!STALL_EXECUTION_STAGE) br_d = br_comb;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) br_q <= 1'b0;
        else        br_q <= br_d;
    end

    assign BRANCH_TAKEN = br_q;
`else
    assign BRANCH_TAKEN = br_comb;
`endif

endmodule

// File: tb/tb_execution_stage.sv
// Directed self-checking bench for execution_stage.
// Immediate assertions, hand-computed expected values.
module tb_execution_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        STALL_EXECUTION_STAGE;
    logic        CLEAR_EXECUTION_STAGE;
    logic [31:0] PC_IN;
    logic [4:0]  RS1_ADDRESS;
    logic [4:0]  RS2_ADDRESS;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic [31:0] IMM_DATA;
    logic [4:0]  ALU_INSTRUCTION;
    logic [2:0]  ALU_IN1_MUX_SELECT;
    logic [2:0]  ALU_IN2_MUX_SELECT;
    logic [31:0] RD_DATA_DM1;
    logic [31:0] RD_DATA_DM2;
    logic [31:0] RD_DATA_DM3;
    logic [31:0] RD_DATA_WB;
    logic [31:0] ALU_OUT;
    logic        BRANCH_TAKEN;

    int tests = 0;
    int fails = 0;

    execution_stage_if sb ();

    execution_stage dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .STALL_EXECUTION_STAGE (STALL_EXECUTION_STAGE),
        .CLEAR_EXECUTION_STAGE (CLEAR_EXECUTION_STAGE),
        .PC_IN                 (PC_IN),
        .RS1_ADDRESS           (RS1_ADDRESS),
        .RS2_ADDRESS           (RS2_ADDRESS),
        .RS1_DATA              (RS1_DATA),
        .RS2_DATA              (RS2_DATA),
        .IMM_DATA              (IMM_DATA),
        .ALU_INSTRUCTION       (ALU_INSTRUCTION),
        .ALU_IN1_MUX_SELECT    (ALU_IN1_MUX_SELECT),
        .ALU_IN2_MUX_SELECT    (ALU_IN2_MUX_SELECT),
        .RD_DATA_DM1           (RD_DATA_DM1),
        .RD_DATA_DM2           (RD_DATA_DM2),
        .RD_DATA_DM3           (RD_DATA_DM3),
        .RD_DATA_WB            (RD_DATA_WB),
        .sb                    (sb),
        .ALU_OUT               (ALU_OUT),
        .BRANCH_TAKEN          (BRANCH_TAKEN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_side(input string tag, input logic [4:0] rd,
                            input logic [2:0] ld, input logic [1:0] st,
                            input logic [31:0] sd, input logic wb,
                            input logic we);
        chk({tag, ".rd"}, {27'd0, sb.RD_ADDRESS_OUT}, {27'd0, rd});
        chk({tag, ".ld"}, {29'd0, sb.DATA_CACHE_LOAD_OUT}, {29'd0, ld});
        chk({tag, ".st"}, {30'd0, sb.DATA_CACHE_STORE_OUT}, {30'd0, st});
        chk({tag, ".sd"}, sb.DATA_CACHE_STORE_DATA_OUT, sd);
        chk({tag, ".wb"}, {31'd0, sb.WRITE_BACK_MUX_SELECT_OUT},
            {31'd0, wb});
        chk({tag, ".we"}, {31'd0, sb.RD_WRITE_ENABLE_OUT}, {31'd0, we});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".alu"}, ALU_OUT, 32'd0);
        chk_side(tag, 5'd0, 3'd0, 2'd0, 32'd0, 1'b0, 1'b0);
`ifdef EX_BRANCH_TAKEN_REG_EN
        chk({tag, ".br"}, {31'd0, BRANCH_TAKEN}, 32'd0);
`endif
    endtask

    task automatic set_op(input logic [2:0] s1, input logic [2:0] s2,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op);
        ALU_IN1_MUX_SELECT = s1;
        ALU_IN2_MUX_SELECT = s2;
        RS1_DATA = a;
        RS2_DATA = b;
        IMM_DATA = b;
        ALU_INSTRUCTION = op;
    endtask

    task automatic branch_check(input string tag, input logic exp);
`ifdef EX_BRANCH_TAKEN_REG_EN
        tick();
`else
        #1;
`endif
        chk(tag, {31'd0, BRANCH_TAKEN}, {31'd0, exp});
    endtask

    initial begin
        RST_N = 1'b0;
        STALL_EXECUTION_STAGE = 1'b0;
        CLEAR_EXECUTION_STAGE = 1'b0;
        PC_IN = 32'h0000_0100;
        RS1_ADDRESS = 5'd1;
        RS2_ADDRESS = 5'd2;
        RD_DATA_DM1 = 32'h0;
        RD_DATA_DM2 = 32'h0;
        RD_DATA_DM3 = 32'h0;
        RD_DATA_WB  = 32'h0;
        set_op(3'd0, 3'd0, 32'h0, 32'h0, 5'd0);
        sb.RD_ADDRESS_IN = 5'd0;
        sb.DATA_CACHE_LOAD_IN = 3'd0;
        sb.DATA_CACHE_STORE_IN = 2'd0;
        sb.DATA_CACHE_STORE_DATA_IN = 32'd0;
        sb.WRITE_BACK_MUX_SELECT_IN = 1'b0;
        sb.RD_WRITE_ENABLE_IN = 1'b0;

        #12;
        chk_zero("reset");
        RST_N = 1'b1;

        // ADD rs1 + imm, sideband capture
        set_op(3'd0, 3'd1, 32'd5, 32'd7, 5'd0);
        sb.RD_ADDRESS_IN = 5'd3;
        sb.DATA_CACHE_LOAD_IN = 3'd2;
        sb.DATA_CACHE_STORE_IN = 2'd1;
        sb.DATA_CACHE_STORE_DATA_IN = 32'hDEAD_BEEF;
        sb.WRITE_BACK_MUX_SELECT_IN = 1'b1;
        sb.RD_WRITE_ENABLE_IN = 1'b1;
        tick();
        chk("add", ALU_OUT, 32'd12);
        chk_side("add", 5'd3, 3'd2, 2'd1, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // forwarding from DM1
        set_op(3'd2, 3'd1, 32'd0, 32'd1, 5'd1);
        RD_DATA_DM1 = 32'h10;
        RS1_ADDRESS = 5'd4;
        tick();
        chk("fwd_dm1", ALU_OUT, 32'h0F);
        RS1_ADDRESS = 5'd0;
        tick();
        chk("fwd_x0", ALU_OUT, 32'hFFFF_FFFF);

        // operand 2 forwarded from WB with rs2 = x0
        RS1_ADDRESS = 5'd1;
        set_op(3'd0, 3'd5, 32'd3, 32'd0, 5'd0);
        RD_DATA_WB = 32'h20;
        RS2_ADDRESS = 5'd0;
        tick();
        chk("fwd2_x0", ALU_OUT, 32'd3);
        RS2_ADDRESS = 5'd9;
        tick();
        chk("fwd2_wb", ALU_OUT, 32'h23);

        // SRA / SRL use only the low 5 bits of operand 2
        set_op(3'd0, 3'd1, 32'h8000_0000, 32'h24, 5'd7);
        tick();
        chk("sra", ALU_OUT, 32'hF800_0000);
        ALU_INSTRUCTION = 5'd6;
        tick();
        chk("srl", ALU_OUT, 32'h0800_0000);
        ALU_INSTRUCTION = 5'd2;
        tick();
        chk("sll", ALU_OUT, 32'h0);

        // signed vs unsigned compare results
        set_op(3'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
        tick();
        chk("slt", ALU_OUT, 32'd1);
        ALU_INSTRUCTION = 5'd4;
        tick();
        chk("sltu", ALU_OUT, 32'd0);
        ALU_INSTRUCTION = 5'd0;
        tick();
        chk("add_wrap", ALU_OUT, 32'd0);

        // LINK and PASSB and logic ops
        set_op(3'd0, 3'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd11);
        tick();
        chk("link", ALU_OUT, 32'h0000_0104);
        ALU_INSTRUCTION = 5'd10;
        tick();
        chk("passb", ALU_OUT, 32'h0FF0_0FF0);
        ALU_INSTRUCTION = 5'd5;
        tick();
        chk("xor", ALU_OUT, 32'hFF00_FF00);
        ALU_INSTRUCTION = 5'd9;
        tick();
        chk("and", ALU_OUT, 32'h00F0_00F0);
        ALU_INSTRUCTION = 5'd8;
        tick();
        chk("or", ALU_OUT, 32'hFFF0_FFF0);
        ALU_IN1_MUX_SELECT = 3'd6;
        tick();
        chk("sel1_zero", ALU_OUT, 32'h0FF0_0FF0);

        // branches
        set_op(3'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd14);
        branch_check("blt", 1'b1);
        ALU_INSTRUCTION = 5'd16;
        branch_check("bltu", 1'b0);
        ALU_INSTRUCTION = 5'd15;
        branch_check("bge", 1'b0);
        ALU_INSTRUCTION = 5'd17;
        branch_check("bgeu", 1'b1);
        set_op(3'd0, 3'd0, 32'h55, 32'h55, 5'd12);
        branch_check("beq", 1'b1);
        ALU_INSTRUCTION = 5'd13;
        branch_check("bne", 1'b0);
        ALU_INSTRUCTION = 5'd20;
        branch_check("op20_nobr", 1'b0);
        ALU_INSTRUCTION = 5'd12;
        tick();
        chk("beq_res", ALU_OUT, 32'd0);

        // stall holds for 3 cycles
        set_op(3'd0, 3'd1, 32'd5, 32'd7, 5'd0);
        sb.RD_ADDRESS_IN = 5'd7;
        tick();
        chk("pre_stall", ALU_OUT, 32'd12);
        STALL_EXECUTION_STAGE = 1'b1;
        set_op(3'd0, 3'd1, 32'd100, 32'd1, 5'd0);
        sb.RD_ADDRESS_IN = 5'd9;
        sb.RD_WRITE_ENABLE_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d", i), ALU_OUT, 32'd12);
            chk($sformatf("stall%0d.rd", i),
                {27'd0, sb.RD_ADDRESS_OUT}, 32'd7);
        end
        chk_side("stall", 5'd7, 3'd2, 2'd1, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // clear beats stall
        CLEAR_EXECUTION_STAGE = 1'b1;
        tick();
        chk_zero("clear");
        CLEAR_EXECUTION_STAGE = 1'b0;
        STALL_EXECUTION_STAGE = 1'b0;
        tick();
        chk("resume", ALU_OUT, 32'd101);

        // async reset mid-stall, between edges
        STALL_EXECUTION_STAGE = 1'b1;
        #3;
        RST_N = 1'b0;
        #1;
        chk_zero("async_rst");
        #2;
        RST_N = 1'b1;
        STALL_EXECUTION_STAGE = 1'b0;
        tick();
        chk("post_rst", ALU_OUT, 32'd101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
